imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 166 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RV32/RV64 immediate generator with a 2-entry output FIFO.
// Occupancy is tracked by a small EMPTY/ONE/FULL state machine; in_ready_o depends only on registered state.
module imm_gen_pipe #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   input  logic [31:0]          inst_i,
   output logic                 in_ready_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [XLEN-1:0]      imm_o,
   output logic [2:0]           fmt_o,
   output logic                 err_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   localparam logic [2:0] FMT_I     = 3'd0;
   localparam logic [2:0] FMT_S     = 3'd1;
   localparam logic [2:0] FMT_B     = 3'd2;
   localparam logic [2:0] FMT_U     = 3'd3;
   localparam logic [2:0] FMT_J     = 3'd4;
   localparam logic [2:0] FMT_SHAMT = 3'd5;
   localparam logic [2:0] FMT_NONE  = 3'd7;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            err;
   } entry_t;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   occ_e                 occ_q, occ_d;
   logic                 rd_ptr_q, rd_ptr_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   entry_t               mem_q [2];
   entry_t               dec;
   entry_t               head;
   logic                 push;
   logic                 pop;

   // Immediate decode; signed casts to XLEN perform the sign extension.
   always_comb begin
      dec.imm = '0;
      dec.fmt = FMT_NONE;
      dec.err = 1'b0;
      case (inst_i[6:0])
         OP_IMM: begin
            if (inst_i[14:12] == 3'b001 || inst_i[14:12] == 3'b101) begin
               dec.fmt      = FMT_SHAMT;
               dec.imm[4:0] = inst_i[24:20];
               if (XLEN == 64) begin
                  dec.imm[5] = inst_i[25];
               end
            end else begin
               dec.fmt = FMT_I;
               dec.imm = XLEN'($signed(inst_i[31:20]));
            end
         end
         OP_LOAD, OP_JALR: begin
            dec.fmt = FMT_I;
            dec.imm = XLEN'($signed(inst_i[31:20]));
         end
         OP_STORE: begin
            dec.fmt = FMT_S;
            dec.imm = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
         end
         OP_BRANCH: begin
            dec.fmt = FMT_B;
            dec.imm = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
         end
         OP_LUI, OP_AUIPC: begin
            dec.fmt = FMT_U;
            dec.imm = XLEN'($signed({inst_i[31:12], 12'b0}));
         end
         OP_JAL: begin
            dec.fmt = FMT_J;
            dec.imm = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
         end
         OP_REG, OP_SYSTEM: begin
            dec.fmt = FMT_NONE;
         end
         default: begin
            dec.err = 1'b1;
         end
      endcase
   end

   // Handshake: a transfer happens on an edge where valid and ready are both high.
   assign in_ready_o  = (occ_q != OCC_FULL);
   assign out_valid_o = (occ_q != OCC_EMPTY);
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;

   always_comb begin
      occ_d     = occ_q;
      rd_ptr_d  = rd_ptr_q ^ pop;
      wr_ptr_d  = wr_ptr_q ^ push;
      err_cnt_d = err_cnt_q;
      case (occ_q)
         OCC_EMPTY: begin
            if (push) occ_d = OCC_ONE;
         end
         OCC_ONE: begin
            if (push && !pop) occ_d = OCC_FULL;
            else if (pop && !push) occ_d = OCC_EMPTY;
         end
         OCC_FULL: begin
            if (pop) occ_d = OCC_ONE;
         end
         default: begin
            occ_d = OCC_EMPTY;
         end
      endcase
      if (push && dec.err && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         occ_q     <= OCC_EMPTY;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         occ_q     <= occ_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // Storage needs no reset: it is only observed while occupancy says it is valid.
   always_ff @(posedge clk_i) begin
      if (!rst_i && push) begin
         mem_q[wr_ptr_q] <= dec;
      end
   end

   assign head      = mem_q[rd_ptr_q];
   assign imm_o     = out_valid_o ? head.imm : '0;
   assign fmt_o     = out_valid_o ? head.fmt : FMT_NONE;
   assign err_o     = out_valid_o && head.err;
   assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32/ERR_CNT_W=2 instance and an XLEN=64 instance share one stimulus stream.
// Expected results are queued on acceptance and compared at the FIFO head.
module tb_imm_gen_pipe;

   typedef struct {
      logic [31:0] inst;
      logic [63:0] imm64;
      logic [31:0] imm32;
      logic [2:0]  fmt;
      logic        err;
   } vec_t;

   logic        clk;
   logic        rst_i;
   logic        in_valid_i;
   logic [31:0] inst_i;
   logic        out_ready_i;

   logic        a_in_ready, a_out_valid, a_err;
   logic [31:0] a_imm;
   logic [2:0]  a_fmt;
   logic [1:0]  a_err_cnt;
   logic        b_in_ready, b_out_valid, b_err;
   logic [63:0] b_imm;
   logic [2:0]  b_fmt;
   logic [7:0]  b_err_cnt;

   // Packed expectation: {imm64[99:36], imm32[35:4], fmt[3:1], err[0]}
   logic [99:0] exp_q[$];
   logic [99:0] cur_exp;
   logic [1:0]  cnt32;
   logic [7:0]  cnt64;
   int          n_push;
   int          n_checks;
   int          n_errors;
   logic        mon_en;
   vec_t        tbl [16];
   logic [6:0]  ops [12];
   logic [1:0]  sat_seq [5];

   imm_gen_pipe #(.XLEN(32), .ERR_CNT_W(2)) u_dut32 (
      .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .inst_i(inst_i),
      .in_ready_o(a_in_ready), .out_valid_o(a_out_valid), .out_ready_i(out_ready_i),
      .imm_o(a_imm), .fmt_o(a_fmt), .err_o(a_err), .err_cnt_o(a_err_cnt)
   );

   imm_gen_pipe #(.XLEN(64), .ERR_CNT_W(8)) u_dut64 (
      .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .inst_i(inst_i),
      .in_ready_o(b_in_ready), .out_valid_o(b_out_valid), .out_ready_i(out_ready_i),
      .imm_o(b_imm), .fmt_o(b_fmt), .err_o(b_err), .err_cnt_o(b_err_cnt)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode written straight from the instruction-set encodings.
   function automatic logic [99:0] model(input logic [31:0] w);
      logic [63:0] i64;
      logic [31:0] i32;
      logic [2:0]  f;
      logic        e;
      i64 = '0;
      f   = 3'd7;
      e   = 1'b0;
      case (w[6:0])
         7'h13: begin
            if (w[14:12] == 3'b001 || w[14:12] == 3'b101) begin
               f = 3'd5;
            end else begin
               f   = 3'd0;
               i64 = {{52{w[31]}}, w[31:20]};
            end
         end
         7'h03, 7'h67: begin f = 3'd0; i64 = {{52{w[31]}}, w[31:20]}; end
         7'h23: begin f = 3'd1; i64 = {{52{w[31]}}, w[31:25], w[11:7]}; end
         7'h63: begin f = 3'd2; i64 = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0}; end
         7'h37, 7'h17: begin f = 3'd3; i64 = {{32{w[31]}}, w[31:12], 12'h000}; end
         7'h6F: begin f = 3'd4; i64 = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; end
         7'h33, 7'h73: f = 3'd7;
         default: e = 1'b1;
      endcase
      i32 = i64[31:0];
      if (f == 3'd5) begin
         i64 = {58'd0, w[25:20]};
         i32 = {27'd0, w[24:20]};
      end
      return {i64, i32, f, e};
   endfunction

   function automatic vec_t mk(input logic [31:0] w, input logic [63:0] i64, input logic [31:0] i32,
                               input logic [2:0] f, input logic e);
      vec_t v;
      v.inst  = w;
      v.imm64 = i64;
      v.imm32 = i32;
      v.fmt   = f;
      v.err   = e;
      return v;
   endfunction

   // Scoreboard: level checks, head compare, then bookkeeping for the coming edge.
   always @(negedge clk) begin : mon
      logic [99:0] h;
      if (mon_en) begin
         check("out_valid32", a_out_valid, exp_q.size() > 0);
         check("in_ready32", a_in_ready, exp_q.size() < 2);
         check("out_valid64", b_out_valid, exp_q.size() > 0);
         check("in_ready64", b_in_ready, exp_q.size() < 2);
         check("err_cnt32", a_err_cnt, cnt32);
         check("err_cnt64", b_err_cnt, cnt64);
         if (a_out_valid && exp_q.size() > 0) begin
            h = exp_q[0];
            check("imm32", a_imm, h[35:4]);
            check("fmt32", a_fmt, h[3:1]);
            check("err32", a_err, h[0]);
            check("imm64", b_imm, h[99:36]);
            check("fmt64", b_fmt, h[3:1]);
            check("err64", b_err, h[0]);
         end
         if (rst_i) begin
            exp_q.delete();
            cnt32 = '0;
            cnt64 = '0;
         end else begin
            if (a_out_valid && out_ready_i && exp_q.size() > 0) begin
               void'(exp_q.pop_front());
            end
            if (in_valid_i && a_in_ready) begin
               exp_q.push_back(cur_exp);
               n_push++;
               if (cur_exp[0]) begin
                  if (cnt32 != 2'd3) cnt32 = cnt32 + 2'd1;
                  if (cnt64 != 8'hFF) cnt64 = cnt64 + 8'd1;
               end
            end
         end
      end
   end

   // Driver tasks
   task automatic drive(input logic v, input logic [31:0] w, input logic [99:0] e, input logic r);
      @(posedge clk);
      #1;
      in_valid_i  = v;
      inst_i      = w;
      cur_exp     = e;
      out_ready_i = r;
   endtask

   task automatic drive_m(input logic v, input logic [31:0] w, input logic r);
      drive(v, w, model(w), r);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_i      = 1'b1;
      in_valid_i = 1'b0;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int left;
      left = 40;
      while (exp_q.size() != 0 && left > 0) begin
         @(posedge clk);
         #2;
         left--;
      end
      check(name, exp_q.size(), 0);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      w      = $urandom();
      w[6:0] = ops[$urandom_range(0, 11)];
      return w;
   endfunction

   initial begin
      n_checks = 0; n_errors = 0; n_push = 0;
      mon_en = 1'b0; cnt32 = '0; cnt64 = '0; cur_exp = '0;
      rst_i = 1'b1; in_valid_i = 1'b0; inst_i = '0; out_ready_i = 1'b0;
      ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73, 7'h00, 7'h7F};
      sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      tbl[0]  = mk(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 3'd0, 1'b0);
      tbl[1]  = mk(32'hFE20AE23, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 3'd1, 1'b0);
      tbl[2]  = mk(32'hFE000CE3, 64'hFFFFFFFFFFFFFFF8, 32'hFFFFFFF8, 3'd2, 1'b0);
      tbl[3]  = mk(32'h123450B7, 64'h0000000012345000, 32'h12345000, 3'd3, 1'b0);
      tbl[4]  = mk(32'h001000EF, 64'h0000000000000800, 32'h00000800, 3'd4, 1'b0);
      tbl[5]  = mk(32'h4030D093, 64'h0000000000000003, 32'h00000003, 3'd5, 1'b0);
      tbl[6]  = mk(32'h02109093, 64'h0000000000000021, 32'h00000001, 3'd5, 1'b0);
      tbl[7]  = mk(32'h800000B7, 64'hFFFFFFFF80000000, 32'h80000000, 3'd3, 1'b0);
      tbl[8]  = mk(32'h80002083, 64'hFFFFFFFFFFFFF800, 32'hFFFFF800, 3'd0, 1'b0);
      tbl[9]  = mk(32'h7FF08067, 64'h00000000000007FF, 32'h000007FF, 3'd0, 1'b0);
      tbl[10] = mk(32'hFFFFF017, 64'hFFFFFFFFFFFFF000, 32'hFFFFF000, 3'd3, 1'b0);
      tbl[11] = mk(32'h8000F093, 64'hFFFFFFFFFFFFF800, 32'hFFFFF800, 3'd0, 1'b0);
      tbl[12] = mk(32'h00B50533, 64'h0, 32'h0, 3'd7, 1'b0);
      tbl[13] = mk(32'h00000073, 64'h0, 32'h0, 3'd7, 1'b0);
      tbl[14] = mk(32'h00000000, 64'h0, 32'h0, 3'd7, 1'b1);
      tbl[15] = mk(32'hFFFFFFFF, 64'h0, 32'h0, 3'd7, 1'b1);

      // Reset values while rst_i is still high
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", a_out_valid, 0);
      check("rst_in_ready", a_in_ready, 1);
      check("rst_imm32", a_imm, 0);
      check("rst_fmt32", a_fmt, 7);
      check("rst_err32", a_err, 0);
      check("rst_errcnt32", a_err_cnt, 0);
      check("rst_imm64", b_imm, 0);
      check("rst_fmt64", b_fmt, 7);
      check("rst_errcnt64", b_err_cnt, 0);
      @(posedge clk);
      #1;
      rst_i  = 1'b0;
      mon_en = 1'b1;

      // Table vectors back-to-back with the consumer always ready
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, tbl[i].inst, {tbl[i].imm64, tbl[i].imm32, tbl[i].fmt, tbl[i].err}, 1'b1);
      end
      drive_m(1'b0, 32'h0, 1'b1);
      wait_drain("drain_table");

      // addi then sw: results appear in consecutive cycles
      drive(1'b1, tbl[0].inst, {tbl[0].imm64, tbl[0].imm32, tbl[0].fmt, tbl[0].err}, 1'b1);
      drive(1'b1, tbl[1].inst, {tbl[1].imm64, tbl[1].imm32, tbl[1].fmt, tbl[1].err}, 1'b1);
      @(negedge clk);
      check("seq_addi_imm", a_imm, 32'hFFFFFFFF);
      check("seq_addi_fmt", a_fmt, 0);
      drive_m(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      check("seq_sw_imm", a_imm, 32'hFFFFFFFC);
      check("seq_sw_fmt", a_fmt, 1);
      wait_drain("drain_seq");

      // Backpressure: exactly two accepted, then release
      begin
         int n0;
         n0 = n_push;
         repeat (6) drive_m(1'b1, rand_inst(), 1'b0);
         drive_m(1'b0, 32'h0, 1'b0);
         @(posedge clk);
         #2;
         check("bp_accepted", n_push - n0, 2);
         check("bp_in_ready", a_in_ready, 0);
         drive_m(1'b0, 32'h0, 1'b1);
         wait_drain("drain_bp");
         check("bp_ready_back", a_in_ready, 1);
      end

      // Error counter saturation with a 2-bit counter
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive_m(1'b1, {25'(k + 1), 7'h00}, 1'b1);
         drive_m(1'b0, 32'h0, 1'b1);
         @(negedge clk);
         check("sat_cnt", a_err_cnt, sat_seq[k]);
         check("sat_err_flag", a_err, 1);
      end
      wait_drain("drain_sat");

      // Reset with two entries buffered and a push pending
      do_reset();
      repeat (3) drive_m(1'b1, 32'h0000_1000, 1'b0);
      @(posedge clk);
      #1;
      rst_i       = 1'b1;
      in_valid_i  = 1'b1;
      out_ready_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i       = 1'b0;
      in_valid_i  = 1'b1;
      inst_i      = 32'h123450B7;
      cur_exp     = model(32'h123450B7);
      out_ready_i = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", a_out_valid, 0);
      check("midrst_in_ready", a_in_ready, 1);
      check("midrst_err_cnt", a_err_cnt, 0);
      drive_m(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      check("first_push_valid", a_out_valid, 1);
      check("first_push_imm", a_imm, 32'h12345000);
      drive_m(1'b0, 32'h0, 1'b1);
      wait_drain("drain_rst");

      // Random traffic against the reference model
      repeat (400) begin
         drive_m($urandom_range(0, 1) == 1, rand_inst(), $urandom_range(0, 3) != 0);
      end
      drive_m(1'b0, 32'h0, 1'b1);
      wait_drain("drain_rand");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
